// File: rtl/status_encoding_pkg.sv
// status_encoding_pkg -- shared host/board protocol definitions.
// Holds the status byte codes sent board->host, the command codes decoded
// host->board, the handshake state encoding and the pending-flag record.
package status_encoding_pkg;

    // Status bytes, board -> host
    localparam logic [7:0] BYTE_OVF       = 8'hFF;  // 11_111111
    localparam logic [7:0] BYTE_NEW_GAME  = 8'h41;  // 01_000001
    localparam logic [7:0] BYTE_TURN_DONE = 8'h42;  // 01_000010
    localparam logic [7:0] BYTE_MOVE_DONE = 8'h00;  // 00_000000
    localparam logic [7:0] BYTE_SCAN_HDR  = 8'hBF;  // 10_111111

    // Command codes, host -> board (used by the host-command decoder)
    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_MOVE_N     = 8'h01;
    localparam logic [7:0] CMD_MOVE_S     = 8'h02;
    localparam logic [7:0] CMD_MOVE_E     = 8'h03;
    localparam logic [7:0] CMD_MOVE_W     = 8'h04;
    localparam logic [7:0] CMD_SCAN       = 8'h10;

    localparam int ROWS = 8;

    // Four-phase transmit handshake states
    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_REQ     = 2'd1,
        TX_RELEASE = 2'd2
    } tx_state_e;

    // Sticky pending flags, ordered by priority (ovf highest)
    typedef struct packed {
        logic ovf;
        logic new_game;
        logic turn_done;
        logic move_done;
        logic scan;
    } pend_t;

    // Board snapshot: element r is row r (bits [8r+7:8r])
    typedef logic [ROWS-1:0][7:0] board_t;

endpackage

// File: rtl/status_encoding_req_ack_tx.sv
// req_ack_tx -- four-phase REQ/ACK byte transmitter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load, load_byte accepted only when idle; byte latched, req raised same edge
//   host_ack        host acknowledge level
//   data_out, req   registered byte and request level to host
//   idle            transmitter ready for a new byte
module req_ack_tx
    import status_encoding_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       host_ack,
    output logic [7:0] data_out,
    output logic       req,
    output logic       idle
);

    tx_state_e  state_q;
    logic [7:0] data_q;
    logic       req_q;

    // An ack already high when REQ is entered completes on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            data_q  <= 8'h00;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (load) begin
                        data_q  <= load_byte;
                        req_q   <= 1'b1;
                        state_q <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (host_ack) begin
                        req_q   <= 1'b0;
                        state_q <= TX_RELEASE;
                    end
                end
                TX_RELEASE: begin
                    if (!host_ack) state_q <= TX_IDLE;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign data_out = data_q;
    assign req      = req_q;
    assign idle     = (state_q == TX_IDLE);

endmodule

// File: rtl/status_encoding.sv
// status_encoding -- collects board events into sticky pending flags and
// sends them to the host as status bytes over a four-phase handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   new_game, user_turn_done, move_done, scan_start   one-cycle event pulses
//   scan_data[63:0]     board occupancy, row r in bits [8r+7:8r]
//   host_ack            host acknowledge level
//   dataStream_out[7:0] status byte; data_outgoing is its request level
//   busy                anything pending, in transfer or mid-frame
module status_encoding
    import status_encoding_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        user_turn_done,
    input  logic        move_done,
    input  logic        scan_start,
    input  logic [63:0] scan_data,
    input  logic        host_ack,
    output logic [7:0]  dataStream_out,
    output logic        data_outgoing,
    output logic        busy
);

    pend_t      pend_q, pend_d, clr;
    board_t     shadow_q, shadow_d;
    logic       frame_q, frame_d;
    logic [2:0] row_q, row_d;
    logic       tx_load, tx_idle;
    logic [7:0] tx_byte;
    logic       scan_drop;

    always_comb begin
        clr      = '0;
        tx_load  = 1'b0;
        tx_byte  = 8'h00;
        frame_d  = frame_q;
        row_d    = row_q;
        shadow_d = shadow_q;

        // Selection: an open frame owns the link until its last row is loaded.
        if (tx_idle) begin
            if (frame_q) begin
                tx_load = 1'b1;
                tx_byte = shadow_q[row_q];
                row_d   = row_q + 3'd1;
                if (row_q == 3'd7) frame_d = 1'b0;
            end else if (pend_q.ovf) begin
                tx_load = 1'b1; tx_byte = BYTE_OVF;       clr.ovf = 1'b1;
            end else if (pend_q.new_game) begin
                tx_load = 1'b1; tx_byte = BYTE_NEW_GAME;  clr.new_game = 1'b1;
            end else if (pend_q.turn_done) begin
                tx_load = 1'b1; tx_byte = BYTE_TURN_DONE; clr.turn_done = 1'b1;
            end else if (pend_q.move_done) begin
                tx_load = 1'b1; tx_byte = BYTE_MOVE_DONE; clr.move_done = 1'b1;
            end else if (pend_q.scan) begin
                tx_load = 1'b1; tx_byte = BYTE_SCAN_HDR;  clr.scan = 1'b1;
                frame_d = 1'b1;
                row_d   = 3'd0;
            end
        end

        // A scan is refused whenever the shadow is still needed, including
        // the cycle its header is being loaded.
        scan_drop = scan_start & (pend_q.scan | frame_q);
        if (scan_start && !scan_drop) shadow_d = scan_data;

        // A pulse collides only with a flag that stays set this cycle; a flag
        // being sent now is free to re-arm.
        pend_d.new_game  = (pend_q.new_game  & ~clr.new_game)  | new_game;
        pend_d.turn_done = (pend_q.turn_done & ~clr.turn_done) | user_turn_done;
        pend_d.move_done = (pend_q.move_done & ~clr.move_done) | move_done;
        pend_d.scan      = (pend_q.scan      & ~clr.scan)      | (scan_start & ~scan_drop);
        pend_d.ovf       = (pend_q.ovf & ~clr.ovf)
                         | (new_game       & pend_q.new_game  & ~clr.new_game)
                         | (user_turn_done & pend_q.turn_done & ~clr.turn_done)
                         | (move_done      & pend_q.move_done & ~clr.move_done)
                         | scan_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            shadow_q <= '0;
            frame_q  <= 1'b0;
            row_q    <= 3'd0;
        end else begin
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            row_q    <= row_d;
        end
    end

    req_ack_tx u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .load_byte (tx_byte),
        .host_ack  (host_ack),
        .data_out  (dataStream_out),
        .req       (data_outgoing),
        .idle      (tx_idle)
    );

    assign busy = ~tx_idle | (|pend_q) | frame_q;

endmodule

// File: tb/tb_status_encoding.sv
module tb_status_encoding;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic        user_turn_done = 1'b0;
    logic        move_done = 1'b0;
    logic        scan_start = 1'b0;
    logic [63:0] scan_data = '0;
    logic        host_ack = 1'b0;
    logic [7:0]  dataStream_out;
    logic        data_outgoing;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          req_cnt = 0;
    int          ack_delay = 3;
    bit          ack_hold = 1'b0;
    logic [7:0]  sb[$];

    status_encoding dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_game       (new_game),
        .user_turn_done (user_turn_done),
        .move_done      (move_done),
        .scan_start     (scan_start),
        .scan_data      (scan_data),
        .host_ack       (host_ack),
        .dataStream_out (dataStream_out),
        .data_outgoing  (data_outgoing),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host: acks ack_delay cycles after the request, drops ack after release.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!ack_hold) begin
                if (data_outgoing && !host_ack) begin
                    if (cnt >= ack_delay) begin host_ack = 1'b1; cnt = 0; end
                    else cnt++;
                end else begin
                    cnt = 0;
                    if (!data_outgoing && host_ack) host_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each new request and checks the handshake.
    initial begin
        logic       prev_req = 1'b0;
        logic       prev_rst = 1'b0;
        logic [7:0] cur = 8'h00;
        logic [7:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && prev_rst) begin
                if (data_outgoing && !prev_req) begin
                    req_cnt++;
                    cur = dataStream_out;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", cur);
                    end else begin
                        exp = sb.pop_front();
                        chk("byte", {56'd0, cur}, {56'd0, exp});
                    end
                end else if (data_outgoing && prev_req) begin
                    chk("hold_data", {56'd0, dataStream_out}, {56'd0, cur});
                end else if (!data_outgoing && prev_req) begin
                    chk("req_until_ack", {63'd0, host_ack}, 64'd1);
                end
            end
            prev_req = data_outgoing;
            prev_rst = rst_n;
        end
    end

    task automatic pulse(input logic ng, input logic td, input logic md, input logic sc);
        new_game = ng; user_turn_done = td; move_done = md; scan_start = sc;
        @(negedge clk);
        new_game = 0; user_turn_done = 0; move_done = 0; scan_start = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !data_outgoing && sb.size() == 0) break;
        end
        if (i == budget) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, sb.size());
        end
        chk({name, "_busy"}, {63'd0, busy}, 64'd0);
        chk({name, "_sb_empty"}, sb.size(), 64'd0);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_outgoing && dataStream_out == b) break;
        end
        if (i == budget) begin
            checks++; errors++;
            $display("FAIL wait_byte_timeout: got %0h expected %0h", dataStream_out, b);
        end
    endtask

    task automatic load_scan();
        for (int r = 0; r < 8; r++) scan_data[8*r +: 8] = 8'(r + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",  {63'd0, data_outgoing}, 64'd0);
        chk("rst_data", {56'd0, dataStream_out}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single new_game, ack after 3 cycles
        sb.push_back(8'h41);
        pulse(1, 0, 0, 0);
        wait_drain("single", 100);

        // 2: three events in the same cycle
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h00);
        pulse(1, 1, 1, 0);
        wait_drain("triple", 200);

        // 3: scan frame, turn_done arriving during row 2 waits for the frame
        load_scan();
        sb.push_back(8'hBF);
        for (int r = 1; r <= 8; r++) sb.push_back(8'(r));
        sb.push_back(8'h42);
        pulse(0, 0, 0, 1);
        wait_byte(8'h03, 200);
        pulse(0, 1, 0, 0);
        wait_drain("scan", 400);

        // 4: move_done twice while the first is still pending -> overflow
        sb.push_back(8'h41); sb.push_back(8'hFF); sb.push_back(8'h00);
        pulse(1, 0, 0, 0);
        wait_byte(8'h41, 50);
        pulse(0, 0, 1, 0);
        @(negedge clk);
        pulse(0, 0, 1, 0);
        wait_drain("ovf", 200);

        // 5: reset while row 4 is being requested
        sb.push_back(8'hBF);
        for (int r = 1; r <= 5; r++) sb.push_back(8'(r));
        pulse(0, 0, 0, 1);
        wait_byte(8'h05, 200);
        rst_n = 1'b0;
        #1;
        chk("midrst_req",  {63'd0, data_outgoing}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_data", {56'd0, dataStream_out}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = req_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_more", req_cnt - r0, 64'd0);
        chk("midrst_sb_empty", sb.size(), 64'd0);
        chk("midrst_idle", {63'd0, busy}, 64'd0);

        // 6: ack held high -> one byte completes, next waits for ack to fall
        ack_hold = 1'b1;
        host_ack = 1'b1;
        sb.push_back(8'h41); sb.push_back(8'h42);
        r0 = req_cnt;
        pulse(1, 1, 0, 0);
        repeat (12) @(negedge clk);
        chk("hold_one_req", req_cnt - r0, 64'd1);
        chk("hold_req_low", {63'd0, data_outgoing}, 64'd0);
        chk("hold_busy",    {63'd0, busy}, 64'd1);
        host_ack = 1'b0;
        ack_hold = 1'b0;
        wait_drain("hold", 100);
        chk("hold_total", req_cnt - r0, 64'd2);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/status_encoding.md
STATUS_ENCODING -- requirements
Module: status_encoding

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 new_game  in  1  one-cycle pulse: player pressed new-game.
REQ-005 user_turn_done  in  1  one-cycle pulse: player finished the move.
REQ-006 move_done  in  1  one-cycle pulse: motor finished the commanded direction step.
REQ-007 scan_start  in  1  one-cycle pulse: the board sensor snapshot on scan_data is valid.
REQ-008 scan_data  in  64  board occupancy; bits [8r+7:8r] hold row r, r=0..7.
REQ-009 host_ack  in  1  host acknowledge level (four-phase).
REQ-010 dataStream_out  out  8  status byte to host.
REQ-011 data_outgoing  out  1  request level; high while dataStream_out is valid.
REQ-012 busy  out  1  high when any byte is pending or in transfer.

Function
REQ-013 Byte codes SHALL be:
- error/overflow = 11_111111
- new game = 01_000001
- turn done = 01_000010
- move done = 00_000000
- scan header = 10_111111, followed by row bytes 0..7 in order.
REQ-014 Each event pulse SHALL set a sticky pending flag on the next clock edge; flags for events arriving in the same cycle SHALL all set.
REQ-015 A pulse arriving while its own flag is already set SHALL set the overflow flag and be otherwise dropped.
REQ-016 scan_start SHALL copy scan_data into a 64-bit shadow register and set scan_pend; a scan_start while scan_pend is set or a scan frame is in progress SHALL be dropped and SHALL set overflow.
REQ-017 FSM states: IDLE, REQ, RELEASE.
REQ-018 IDLE: with no frame in progress, select the highest-priority pending item in the order overflow > new_game > turn_done > move_done > scan. Load its byte into dataStream_out, clear its flag, assert data_outgoing on the same edge, and go to REQ.
REQ-019 REQ: hold dataStream_out and data_outgoing stable; on host_ack==1, deassert data_outgoing and go to RELEASE.
REQ-020 RELEASE: wait for host_ack==0, then return to IDLE; byte-to-byte spacing is therefore at least one IDLE cycle.
REQ-021 A scan frame (header plus 8 rows) SHALL be atomic: once the header is loaded, IDLE SHALL send the next row from a 3-bit row counter ahead of any pending event, until row 7 completes.
REQ-022 An event arriving during a frame SHALL stay pending and be sent after row 7.
REQ-023 busy = (state != IDLE) | any pending flag | frame in progress.
REQ-024 host_ack already high on entry to REQ SHALL complete the phase on the next edge (no deadlock).

Reset
REQ-025 On rst_n low, asynchronously:
- state=IDLE
- dataStream_out=0, data_outgoing=0, busy=0
- all pending and overflow flags=0
- row counter=0, shadow register=0
REQ-026 Reset mid-transfer or mid-frame SHALL abandon it; no partial frame SHALL resume.

Structure
REQ-027 Byte codes and state encodings SHALL live in the shared protocol package, beside the command codes used by the host-command decoder.
REQ-028 The four-phase REQ/RELEASE handshake MAY be a sub-module named req_ack_tx; the pending/priority logic stays in status_encoding.

Verification
REQ-029 The bench SHALL cover:
- new_game pulse, host acks after 3 cycles -> single byte 0x41 with data_outgoing held until ack, then busy=0.
- new_game, user_turn_done and move_done in the same cycle -> bytes 0x41, 0x42, 0x00 in that order.
- scan_start with row r = r+1, plus user_turn_done during row 2 -> 0xBF, 0x01..0x08, then 0x42.
- move_done twice while the first is still pending -> 0xFF sent first, then exactly one 0x00.
- rst_n low while in REQ during row 4 -> data_outgoing=0 immediately, busy=0, and no further bytes after release.
- host_ack held high -> each byte completes, and the next byte is not requested until ack falls.
